redmule_w_sequencer: RTL
========================

Name: redmule_w_sequencer

Overview:
- Controller that sequences the W operand buffer.
- Accepts W rows from the streamer via a valid/ready handshake and generates the buffer's load, shift, width and height controls.
- Walks a W matrix of configurable column count in D-wide column tiles: load H rows, then issue one full tile of shifts paced by the engine, then move to the next tile.
- Sits between the streamer, the engine scheduler and the W buffer.

Parameters:
- DW, 288, W stream beat width in bits.
- BITW, 16, element width in bits; D = DW/BITW elements per beat (default 18).
- H, ARRAY_HEIGHT (4 for tests), rows per tile = PE rows.
- N_REGS, PIPE_REGS (3 for tests), pipeline registers per PE. Derived: C = (D+N_REGS)/(N_REGS+1), SHIFTS = C*(N_REGS+1) (default 5 and 20).
- CNT_W, 16, width of the column/tile counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear; returns the block to IDLE and zeroes all counters
- start_i  in  1  single-cycle job start; sampled only in IDLE
- cfg_cols_i  in  CNT_W  total W columns; must be >= 1
- cfg_rows_i  in  $clog2(H+1)  valid W rows, 1..H
- w_valid_i  in  1  streamer has a W row beat
- w_ready_o  out  1  sequencer accepts the beat
- shift_req_i  in  1  engine requests one W shift this cycle
- load_o  out  1  buffer load strobe (= w_valid_i & w_ready_o)
- shift_o  out  1  buffer shift strobe
- width_o  out  $clog2(D+1)  valid columns in the current tile
- height_o  out  $clog2(H+1)  valid rows (latched cfg_rows_i)
- tile_ready_o  out  1  a full tile is loaded and shifts may be issued
- busy_o  out  1  job in progress (state != IDLE)
- done_o  out  1  one-cycle pulse after the last shift of the last tile

Behaviour:
- Reset or clear: state = IDLE, all counters 0, width_o = 0, height_o = 0; all strobes and flags low.
- Clear has priority over every other event.
- Registers latched on start in IDLE: cols_left = cfg_cols_i, height_o = cfg_rows_i, width_o = min(D, cfg_cols_i).
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: start_i -> LOAD. All other inputs are ignored.
- LOAD:
  - w_ready_o = 1; load_o = w_valid_i, combinational and same-cycle.
  - row_cnt increments on each load.
  - When a load occurs with row_cnt == H-1: row_cnt <= 0, next state SHIFT.
  - Exactly H beats are always consumed, even if cfg_rows_i < H; the buffer zero-pads via height_o.
- SHIFT:
  - tile_ready_o = 1; w_ready_o = 0; shift_o = shift_req_i.
  - shift_cnt increments per shift.
  - On a shift with shift_cnt == SHIFTS-1: shift_cnt <= 0 and cols_left <= cols_left - width_o.
  - At that point, if cols_left > width_o: width_o <= min(D, cols_left - width_o), next state LOAD. Otherwise next state DONE.
  - shift_req_i outside SHIFT is ignored; shift_o stays 0.
- DONE: done_o = 1 for exactly one cycle, then IDLE; busy_o drops in the IDLE cycle.
- Start while busy is ignored; the configuration is not re-latched.
- Width arithmetic: compare before subtracting, so there is no underflow. The final tile width is cols % D, or D if that remainder is 0.
- Back-to-back handling: loads in consecutive cycles are accepted at full rate, and shifts in consecutive cycles are issued at full rate. Moving between LOAD and SHIFT adds no bubble beyond the single state-register update.
- Asynchronous reset mid-job aborts immediately with no done_o.
- A clear mid-job behaves identically, but takes effect at the next clock edge.

Test Plan:
- Single tile: cfg_cols=10, cfg_rows=4, 4 beats, then 20 shift_req -> 4 load_o pulses, width_o=10, height_o=4, 20 shift_o, done_o one cycle after the 20th shift.
- Multi tile: cfg_cols=40 -> tiles of width 18, 18, 4; 12 load_o and 60 shift_o total; width_o updates to 18, 18, 4 at each LOAD entry; one done_o.
- Exact multiple: cfg_cols=36 -> two tiles, both width_o=18; DONE after 40 shifts.
- Stalls: random gaps on w_valid_i and shift_req_i -> load_o only when w_valid_i=1 in LOAD; shift_o only in SHIFT; shift_req_i during LOAD produces no shift_o; counts unchanged versus the no-stall case.
- Clear mid-job: clear_i after 2 of 4 loads -> next cycle busy_o=0, w_ready_o=0, width_o=0; a subsequent start runs a full job correctly.
- Start while busy, and short height: start_i pulsed in SHIFT is ignored; cfg_rows=2 still consumes 4 beats with height_o=2.

Source files
------------

// File: rtl/redmule_w_sequencer.sv
// W operand buffer sequencer: takes H streamer rows per column tile, then issues one
// full tile of engine-paced shifts, walking the W matrix in D-wide column tiles.
module redmule_w_sequencer #(
    parameter int unsigned DW     = 288,
    parameter int unsigned BITW   = 16,
    parameter int unsigned H      = 4,
    parameter int unsigned N_REGS = 3,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned D     = DW / BITW,
    localparam int unsigned WW    = $clog2(D + 1),
    localparam int unsigned HW    = $clog2(H + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cfg_cols_i,
    input  logic [HW-1:0]    cfg_rows_i,
    input  logic             w_valid_i,
    output logic             w_ready_o,
    input  logic             shift_req_i,
    output logic             load_o,
    output logic             shift_o,
    output logic [WW-1:0]    width_o,
    output logic [HW-1:0]    height_o,
    output logic             tile_ready_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned C      = (D + N_REGS) / (N_REGS + 1);
    localparam int unsigned SHIFTS = C * (N_REGS + 1);
    localparam int unsigned RW     = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned SW     = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;

    localparam logic [RW-1:0]    ROW_LAST   = RW'(H - 1);
    localparam logic [SW-1:0]    SHIFT_LAST = SW'(SHIFTS - 1);
    localparam logic [CNT_W-1:0] D_CNT      = CNT_W'(D);
    localparam logic [WW-1:0]    D_WID      = WW'(D);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_r, state_s;
    logic [RW-1:0]      row_cnt_r, row_cnt_s;
    logic [SW-1:0]      shift_cnt_r, shift_cnt_s;
    logic [CNT_W-1:0]   cols_left_r, cols_left_s;
    logic [WW-1:0]      width_r, width_s;
    logic [HW-1:0]      height_r, height_s;
    logic [CNT_W-1:0]   width_ext_s;
    logic [CNT_W-1:0]   remain_s;
    logic               w_ready_s, tile_ready_s, load_s, shift_s, done_s;

    // Tile width is the remaining column count clipped to one beat of D elements.
    function automatic logic [WW-1:0] tile_width(input logic [CNT_W-1:0] cols);
        logic [WW-1:0] w;
        if (cols >= D_CNT) begin
            w = D_WID;
        end else begin
            w = cols[WW-1:0];
        end
        return w;
    endfunction

    // Next-state, counter updates and per-state strobe decode.
    always_comb begin
        state_s      = state_r;
        row_cnt_s    = row_cnt_r;
        shift_cnt_s  = shift_cnt_r;
        cols_left_s  = cols_left_r;
        width_s      = width_r;
        height_s     = height_r;
        w_ready_s    = 1'b0;
        tile_ready_s = 1'b0;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        done_s       = 1'b0;
        width_ext_s  = CNT_W'(width_r);
        // Only consumed once cols_left_r >= width_r is guaranteed, so it never wraps.
        remain_s     = cols_left_r - width_ext_s;

        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s     = ST_LOAD;
                    cols_left_s = cfg_cols_i;
                    height_s    = cfg_rows_i;
                    width_s     = tile_width(cfg_cols_i);
                    row_cnt_s   = '0;
                    shift_cnt_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_ready_s = 1'b1;
                load_s    = w_valid_i;
                if (w_valid_i) begin
                    if (row_cnt_r == ROW_LAST) begin
                        row_cnt_s = '0;
                        state_s   = ST_SHIFT;
                    end else begin
                        row_cnt_s = row_cnt_r + RW'(1);
                    end
                end else begin
                    row_cnt_s = row_cnt_r;
                end
            end
            ST_SHIFT: begin
                tile_ready_s = 1'b1;
                shift_s      = shift_req_i;
                if (shift_req_i) begin
                    if (shift_cnt_r == SHIFT_LAST) begin
                        shift_cnt_s = '0;
                        cols_left_s = remain_s;
                        if (cols_left_r > width_ext_s) begin
                            width_s = tile_width(remain_s);
                            state_s = ST_LOAD;
                        end else begin
                            state_s = ST_DONE;
                        end
                    end else begin
                        shift_cnt_s = shift_cnt_r + SW'(1);
                    end
                end else begin
                    shift_cnt_s = shift_cnt_r;
                end
            end
            ST_DONE: begin
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; clear dominates any in-flight update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            row_cnt_r   <= '0;
            shift_cnt_r <= '0;
            cols_left_r <= '0;
            width_r     <= '0;
            height_r    <= '0;
        end else if (clear_i) begin
            state_r     <= ST_IDLE;
            row_cnt_r   <= '0;
            shift_cnt_r <= '0;
            cols_left_r <= '0;
            width_r     <= '0;
            height_r    <= '0;
        end else begin
            state_r     <= state_s;
            row_cnt_r   <= row_cnt_s;
            shift_cnt_r <= shift_cnt_s;
            cols_left_r <= cols_left_s;
            width_r     <= width_s;
            height_r    <= height_s;
        end
    end

    assign w_ready_o    = w_ready_s;
    assign load_o       = load_s;
    assign shift_o      = shift_s;
    assign tile_ready_o = tile_ready_s;
    assign done_o       = done_s;
    assign busy_o       = (state_r != ST_IDLE);
    assign width_o      = width_r;
    assign height_o     = height_r;

endmodule
